// File: rtl/mycpu_alu_arbiter.sv
// Round-robin arbiter that shares one combinational EX-stage ALU between the main pipeline (port 0)
// and an auxiliary issuer (port 1). It keeps one operation in flight and registers the response.
module mycpu_alu_arbiter #(
   parameter int DW   = 32,
   parameter int OPW  = 4,
   parameter int TAGW = 5
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [DW-1:0]   req0_a,
   input  logic [DW-1:0]   req0_b,
   input  logic [OPW-1:0]  req0_op,
   input  logic [TAGW-1:0] req0_tag,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [DW-1:0]   req1_a,
   input  logic [DW-1:0]   req1_b,
   input  logic [OPW-1:0]  req1_op,
   input  logic [TAGW-1:0] req1_tag,
   output logic [DW-1:0]   alu_a,
   output logic [DW-1:0]   alu_b,
   output logic [OPW-1:0]  alu_op,
   input  logic [DW-1:0]   alu_result,
   input  logic            alu_ovf,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [DW-1:0]   rsp_result,
   output logic            rsp_ovf,
   output logic [TAGW-1:0] rsp_tag
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic            last_grant_q, last_grant_d;
   logic [DW-1:0]   alu_a_q, alu_a_d;
   logic [DW-1:0]   alu_b_q, alu_b_d;
   logic [OPW-1:0]  alu_op_q, alu_op_d;
   logic [TAGW-1:0] tag_q, tag_d;
   logic            id_q, id_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [DW-1:0]   rsp_result_q, rsp_result_d;
   logic            rsp_ovf_q, rsp_ovf_d;
   logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
   logic            rsp_id_q, rsp_id_d;

   logic accept_en;
   logic grant0;
   logic grant1;
   logic accept;

   // Under contention the port that did not win last time gets the ALU.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid && req1_valid) begin
         grant0 = last_grant_q;
         grant1 = ~last_grant_q;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
   end

   assign accept_en  = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
   assign accept     = accept_en && (grant0 || grant1);
   assign req0_ready = accept_en && grant0;
   assign req1_ready = accept_en && grant1;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_op_d     = alu_op_q;
      tag_d        = tag_q;
      id_d         = id_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_ovf_d    = rsp_ovf_q;
      rsp_tag_d    = rsp_tag_q;
      rsp_id_d     = rsp_id_q;

      case (state_q)
         IDLE: begin
            if (accept) state_d = EXEC;
         end
         EXEC: begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = alu_result;
            rsp_ovf_d    = alu_ovf;
            rsp_tag_d    = tag_q;
            rsp_id_d     = id_q;
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = accept ? EXEC : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // ALU operand registers only move on an accept, so the ALU inputs stay quiet otherwise.
      if (accept) begin
         last_grant_d = grant1;
         id_d         = grant1;
         alu_a_d      = grant1 ? req1_a   : req0_a;
         alu_b_d      = grant1 ? req1_b   : req0_b;
         alu_op_d     = grant1 ? req1_op  : req0_op;
         tag_d        = grant1 ? req1_tag : req0_tag;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         tag_q        <= '0;
         id_q         <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_ovf_q    <= 1'b0;
         rsp_tag_q    <= '0;
         rsp_id_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_op_q     <= alu_op_d;
         tag_q        <= tag_d;
         id_q         <= id_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_ovf_q    <= rsp_ovf_d;
         rsp_tag_q    <= rsp_tag_d;
         rsp_id_q     <= rsp_id_d;
      end
   end

   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_op     = alu_op_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_ovf    = rsp_ovf_q;
   assign rsp_tag    = rsp_tag_q;
   assign rsp_id     = rsp_id_q;

endmodule

// File: tb/tb_mycpu_alu_arbiter.sv
// Directed bench for mycpu_alu_arbiter. A small behavioural ALU sits on the alu_* ports.
module tb_mycpu_alu_arbiter;

   localparam int DW   = 32;
   localparam int OPW  = 4;
   localparam int TAGW = 5;

   localparam logic [OPW-1:0] OP_ADD = 4'd0;
   localparam logic [OPW-1:0] OP_SUB = 4'd1;
   localparam logic [OPW-1:0] OP_AND = 4'd2;

   logic            clk = 1'b0;
   logic            resetn;
   logic            req0_valid, req0_ready;
   logic [DW-1:0]   req0_a, req0_b;
   logic [OPW-1:0]  req0_op;
   logic [TAGW-1:0] req0_tag;
   logic            req1_valid, req1_ready;
   logic [DW-1:0]   req1_a, req1_b;
   logic [OPW-1:0]  req1_op;
   logic [TAGW-1:0] req1_tag;
   logic [DW-1:0]   alu_a, alu_b;
   logic [OPW-1:0]  alu_op;
   logic [DW-1:0]   alu_result;
   logic            alu_ovf;
   logic            rsp_valid, rsp_ready, rsp_id, rsp_ovf;
   logic [DW-1:0]   rsp_result;
   logic [TAGW-1:0] rsp_tag;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   // Behavioural ALU: ADD/SUB with signed overflow, AND, else OR.
   always_comb begin
      alu_result = alu_a | alu_b;
      alu_ovf    = 1'b0;
      case (alu_op)
         OP_ADD: begin
            alu_result = alu_a + alu_b;
            alu_ovf    = (alu_a[DW-1] == alu_b[DW-1]) && (alu_result[DW-1] != alu_a[DW-1]);
         end
         OP_SUB: begin
            alu_result = alu_a - alu_b;
            alu_ovf    = (alu_a[DW-1] != alu_b[DW-1]) && (alu_result[DW-1] != alu_a[DW-1]);
         end
         OP_AND: alu_result = alu_a & alu_b;
         default: ;
      endcase
   end

   mycpu_alu_arbiter #(.DW(DW), .OPW(OPW), .TAGW(TAGW)) dut (
      .clk(clk), .resetn(resetn),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req0_op(req0_op), .req0_tag(req0_tag),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .req1_op(req1_op), .req1_tag(req1_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result), .alu_ovf(alu_ovf),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_tag(rsp_tag)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic id,
                          input logic [DW-1:0] res, input logic ovf, input logic [TAGW-1:0] t);
      chk({tag, ".valid"}, 64'(rsp_valid), 64'(v));
      chk({tag, ".id"}, 64'(rsp_id), 64'(id));
      chk({tag, ".result"}, 64'(rsp_result), 64'(res));
      chk({tag, ".ovf"}, 64'(rsp_ovf), 64'(ovf));
      chk({tag, ".tag"}, 64'(rsp_tag), 64'(t));
   endtask

   task automatic chk_rdy(input string tag, input logic r0, input logic r1);
      chk({tag, ".r0"}, 64'(req0_ready), 64'(r0));
      chk({tag, ".r1"}, 64'(req1_ready), 64'(r1));
   endtask

   initial begin
      resetn = 1'b0; rsp_ready = 1'b0;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; req0_tag = '0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; req1_tag = '0;
      step(); step();

      // Reset state
      chk_rsp("rst", 1'b0, 1'b0, 32'h0, 1'b0, 5'd0);
      chk("rst.alu_a", 64'(alu_a), 64'h0);
      chk("rst.alu_op", 64'(alu_op), 64'h0);
      chk_rdy("rst", 1'b0, 1'b0);
      resetn = 1'b1;
      step();

      // Single request: ADD 5+7 tag 3 on port 0
      rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = OP_ADD; req0_tag = 5'd3;
      #1;
      chk_rdy("single.T", 1'b1, 1'b0);
      step();
      req0_valid = 1'b0;
      chk("single.exec_valid", 64'(rsp_valid), 64'h0);
      chk("single.alu_a", 64'(alu_a), 64'd5);
      chk("single.alu_b", 64'(alu_b), 64'd7);
      chk("single.alu_op", 64'(alu_op), 64'(OP_ADD));
      step();
      chk_rsp("single.T2", 1'b1, 1'b0, 32'd12, 1'b0, 5'd3);
      step();
      chk("single.drain", 64'(rsp_valid), 64'h0);
      chk("single.hold_a", 64'(alu_a), 64'd5);

      // Overflow on port 1 alone (also sets last_grant=1)
      req1_valid = 1'b1; req1_a = 32'h7FFFFFFF; req1_b = 32'd1; req1_op = OP_ADD; req1_tag = 5'd9;
      #1;
      chk_rdy("ovf.T", 1'b0, 1'b1);
      step();
      req1_valid = 1'b0;
      step();
      chk_rsp("ovf", 1'b1, 1'b1, 32'h80000000, 1'b1, 5'd9);
      step();
      chk("ovf.drain", 64'(rsp_valid), 64'h0);

      // Contention: port 0 wins first after port 1, then alternation
      req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3;  req0_op = OP_SUB; req0_tag = 5'd1;
      req1_valid = 1'b1; req1_a = 32'd6;  req1_b = 32'd12; req1_op = OP_AND; req1_tag = 5'd2;
      #1;
      chk_rdy("cont.c0", 1'b1, 1'b0);
      step();
      chk_rdy("cont.c1", 1'b0, 1'b0);
      chk("cont.c1.alu_a", 64'(alu_a), 64'd10);
      step();
      chk_rsp("cont.c2", 1'b1, 1'b0, 32'd7, 1'b0, 5'd1);
      chk_rdy("cont.c2", 1'b0, 1'b1);
      step();
      chk("cont.c3.valid", 64'(rsp_valid), 64'h0);
      chk("cont.c3.alu_a", 64'(alu_a), 64'd6);
      step();
      chk_rsp("cont.c4", 1'b1, 1'b1, 32'd4, 1'b0, 5'd2);
      chk_rdy("cont.c4", 1'b1, 1'b0);
      step();
      chk("cont.c5.alu_a", 64'(alu_a), 64'd10);
      step();
      chk_rsp("cont.c6", 1'b1, 1'b0, 32'd7, 1'b0, 5'd1);

      // Backpressure: hold response for 5 cycles
      rsp_ready = 1'b0;
      #1;
      for (int i = 0; i < 5; i++) begin
         chk_rdy("bp.hold", 1'b0, 1'b0);
         chk_rsp("bp.hold", 1'b1, 1'b0, 32'd7, 1'b0, 5'd1);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk_rdy("bp.release", 1'b0, 1'b1);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("bp.exec_valid", 64'(rsp_valid), 64'h0);
      chk("bp.exec_alu_a", 64'(alu_a), 64'd6);
      step();
      chk_rsp("bp.rsp", 1'b1, 1'b1, 32'd4, 1'b0, 5'd2);
      step();
      chk("bp.idle", 64'(rsp_valid), 64'h0);

      // Reset in the middle of EXEC discards the operation
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_op = OP_ADD; req0_tag = 5'd5;
      step();
      req0_valid = 1'b0;
      chk("mid.exec_alu_a", 64'(alu_a), 64'd1);
      resetn = 1'b0;
      #1;
      chk("mid.alu_a", 64'(alu_a), 64'h0);
      chk("mid.alu_b", 64'(alu_b), 64'h0);
      chk_rsp("mid", 1'b0, 1'b0, 32'h0, 1'b0, 5'd0);
      step();
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("mid.no_rsp", 64'(rsp_valid), 64'h0);
      end

      // After reset port 0 wins the first contention
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      chk_rdy("post_rst", 1'b1, 1'b0);
      step();
      req0_valid = 1'b0;
      step();
      chk_rsp("post_rst.rsp", 1'b1, 1'b0, 32'd3, 1'b0, 5'd5);
      chk_rdy("post_rst.next", 1'b0, 1'b1);
      step();
      req1_valid = 1'b0;
      step();
      chk_rsp("post_rst.rsp1", 1'b1, 1'b1, 32'd4, 1'b0, 5'd2);
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
